// File: rtl/dcache_controller_pkg.sv
// rtl/dcache_controller_pkg.sv - shared constants, state encoding and helpers for the data-cache controller
package dcache_controller_pkg;

   localparam int DADDR_SIZE           = 32;
   localparam int DBLOCK_SIZE          = 16;
   localparam int DBLOCK_SIZE_BITS     = $clog2(DBLOCK_SIZE);
   localparam int DSET_INDEX_SIZE      = 4;
   localparam int DTAG_SIZE            = DADDR_SIZE - DSET_INDEX_SIZE - DBLOCK_SIZE_BITS;
   localparam int DMEM_BLOCK_ADDR_SIZE = DTAG_SIZE + DSET_INDEX_SIZE;

   typedef enum logic [1:0] {
      DC_IDLE   = 2'd0,
      DC_WB     = 2'd1,
      DC_FILL   = 2'd2,
      DC_REFILL = 2'd3
   } dc_state_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/dcache_perf_counters.sv
// rtl/dcache_perf_counters.sv - saturating hit/miss/writeback event counters (used when DCACHE_PERF_CNT_EN is defined)
module dcache_perf_counters
   import dcache_controller_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        hit_evt,
   input  logic        miss_evt,
   input  logic        wb_evt,
   output logic [31:0] perf_hits,
   output logic [31:0] perf_misses,
   output logic [31:0] perf_writebacks
);

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_hits       <= '0;
         perf_misses     <= '0;
         perf_writebacks <= '0;
      end else begin
         if (hit_evt)  perf_hits       <= sat_inc32(perf_hits);
         if (miss_evt) perf_misses     <= sat_inc32(perf_misses);
         if (wb_evt)   perf_writebacks <= sat_inc32(perf_writebacks);
      end
   end

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - data-cache miss/writeback/refill FSM; DCACHE_PERF_CNT_EN adds perf counter outputs
module dcache_controller
   import dcache_controller_pkg::*;
#(
   parameter  int ADDR_W      = DADDR_SIZE,
   parameter  int BLOCK_BYTES = DBLOCK_SIZE,
   parameter  int SET_INDEX_W = DSET_INDEX_SIZE,
   localparam int OFS_W       = $clog2(BLOCK_BYTES),
   localparam int TAG_W       = ADDR_W - SET_INDEX_W - OFS_W,
   localparam int BA_W        = TAG_W + SET_INDEX_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cpu_ren,
   input  logic                     cpu_wen,
   input  logic [ADDR_W-1:0]        cpu_addr,
   input  logic [31:0]              cpu_wdata,
   input  logic [3:0]               cpu_byte_en,
   output logic [31:0]              cpu_rdata,
   output logic                     cpu_stall,
   output logic                     c_ren,
   output logic                     c_wen,
   output logic                     c_memWen,
   output logic [BLOCK_BYTES-1:0]   c_bytesAccess,
   output logic [BA_W-1:0]          c_blockAddr,
   output logic [8*BLOCK_BYTES-1:0] c_dataIn,
   input  logic                     c_hit,
   input  logic                     c_dirty,
   input  logic [TAG_W-1:0]         c_victimTag,
   input  logic [8*BLOCK_BYTES-1:0] c_dataOut,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [BA_W-1:0]          mem_addr,
   output logic [8*BLOCK_BYTES-1:0] mem_wdata,
   input  logic [8*BLOCK_BYTES-1:0] mem_rdata,
   input  logic                     mem_ready
`ifdef DCACHE_PERF_CNT_EN
   ,
   output logic [31:0]              perf_hits,
   output logic [31:0]              perf_misses,
   output logic [31:0]              perf_writebacks
`endif
);

   localparam int WORDS  = BLOCK_BYTES / 4;
   localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   dc_state_t               state, state_nxt;
   logic [BA_W-1:0]         lat_baddr;
   logic [TAG_W-1:0]        lat_vtag;
   logic [8*BLOCK_BYTES-1:0] blk_buf;
   logic                    req;
   logic                    miss;
   logic [WSEL_W-1:0]       word;

   assign req  = cpu_ren | cpu_wen;
   assign miss = (state == DC_IDLE) && req && !c_hit;
   assign word = WSEL_W'(cpu_addr >> 2) & WSEL_W'(WORDS - 1);

   assign cpu_rdata = c_dataOut[32*word +: 32];
   assign mem_wdata = blk_buf;

   always_ff @(posedge clk) begin
      if (rst) state <= DC_IDLE;
      else     state <= state_nxt;
   end

   // One block buffer serves both directions: the victim is no longer
   // needed once its writeback completes, so the fetched block replaces it.
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_baddr <= '0;
         lat_vtag  <= '0;
         blk_buf   <= '0;
      end else if (miss) begin
         lat_baddr <= cpu_addr[ADDR_W-1:OFS_W];
         lat_vtag  <= c_victimTag;
         blk_buf   <= c_dataOut;
      end else if (state == DC_FILL && mem_ready) begin
         blk_buf   <= mem_rdata;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         DC_IDLE:   if (miss) state_nxt = c_dirty ? DC_WB : DC_FILL;
         DC_WB:     if (mem_ready) state_nxt = DC_FILL;
         DC_FILL:   if (mem_ready) state_nxt = DC_REFILL;
         DC_REFILL: state_nxt = DC_IDLE;
         default:   state_nxt = DC_IDLE;
      endcase
   end

   always_comb begin
      c_ren         = 1'b0;
      c_wen         = 1'b0;
      c_memWen      = 1'b0;
      c_bytesAccess = '0;
      c_blockAddr   = lat_baddr;
      c_dataIn      = '0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = lat_baddr;
      cpu_stall     = 1'b1;
      unique case (state)
         DC_IDLE: begin
            c_ren         = cpu_ren & ~cpu_wen;
            c_wen         = cpu_wen;
            c_bytesAccess = BLOCK_BYTES'(cpu_byte_en) << (4 * word);
            c_blockAddr   = cpu_addr[ADDR_W-1:OFS_W];
            c_dataIn      = {WORDS{cpu_wdata}};
            cpu_stall     = req & ~c_hit;
         end
         DC_WB: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = {lat_vtag, lat_baddr[SET_INDEX_W-1:0]};
         end
         DC_FILL: begin
            mem_req = 1'b1;
         end
         DC_REFILL: begin
            c_memWen = 1'b1;
            c_dataIn = blk_buf;
         end
         default: ;
      endcase
   end

`ifdef DCACHE_PERF_CNT_EN
   logic hit_evt;
   logic wb_evt;

   assign hit_evt = (state == DC_IDLE) && req && c_hit;
   assign wb_evt  = (state == DC_WB) && mem_ready;

   dcache_perf_counters u_perf (
      .clk             (clk),
      .rst             (rst),
      .hit_evt         (hit_evt),
      .miss_evt        (miss),
      .wb_evt          (wb_evt),
      .perf_hits       (perf_hits),
      .perf_misses     (perf_misses),
      .perf_writebacks (perf_writebacks)
   );
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - self-checking bench for dcache_controller with array and memory models
module tb_dcache_controller;

   logic         clk = 1'b0;
   logic         rst;
   logic         cpu_ren, cpu_wen;
   logic [31:0]  cpu_addr, cpu_wdata;
   logic [3:0]   cpu_byte_en;
   logic [31:0]  cpu_rdata;
   logic         cpu_stall;
   logic         c_ren, c_wen, c_memWen;
   logic [15:0]  c_bytesAccess;
   logic [27:0]  c_blockAddr;
   logic [127:0] c_dataIn;
   logic         c_hit, c_dirty;
   logic [23:0]  c_victimTag;
   logic [127:0] c_dataOut;
   logic         mem_req, mem_we;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata, mem_rdata;
   logic         mem_ready;
`ifdef DCACHE_PERF_CNT_EN
   logic [31:0]  perf_hits, perf_misses, perf_writebacks;
`endif

   always #5 clk = ~clk;

   dcache_controller dut (
      .clk(clk), .rst(rst),
      .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_byte_en(cpu_byte_en),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .c_ren(c_ren), .c_wen(c_wen), .c_memWen(c_memWen),
      .c_bytesAccess(c_bytesAccess), .c_blockAddr(c_blockAddr), .c_dataIn(c_dataIn),
      .c_hit(c_hit), .c_dirty(c_dirty), .c_victimTag(c_victimTag), .c_dataOut(c_dataOut),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef DCACHE_PERF_CNT_EN
      , .perf_hits(perf_hits), .perf_misses(perf_misses), .perf_writebacks(perf_writebacks)
`endif
   );

   // Direct-mapped cache array model, 16 sets
   logic         arr_valid [16];
   logic         arr_dirty [16];
   logic [23:0]  arr_tag   [16];
   logic [127:0] arr_data  [16];
   logic [3:0]   a_idx;
   logic         inv_all, pre_en, pre_valid, pre_dirty;
   logic [3:0]   pre_idx;
   logic [23:0]  pre_tag;
   logic [127:0] pre_data;

   assign a_idx       = c_blockAddr[3:0];
   assign c_hit       = arr_valid[a_idx] && (arr_tag[a_idx] == c_blockAddr[27:4]);
   assign c_dirty     = arr_valid[a_idx] && arr_dirty[a_idx];
   assign c_victimTag = arr_tag[a_idx];
   assign c_dataOut   = arr_data[a_idx];

   always @(posedge clk) begin
      if (inv_all) begin
         for (int i = 0; i < 16; i++) begin
            arr_valid[i] <= 1'b0; arr_dirty[i] <= 1'b0;
            arr_tag[i]   <= '0;   arr_data[i]  <= '0;
         end
      end else if (pre_en) begin
         arr_valid[pre_idx] <= pre_valid; arr_dirty[pre_idx] <= pre_dirty;
         arr_tag[pre_idx]   <= pre_tag;   arr_data[pre_idx]  <= pre_data;
      end else if (c_memWen) begin
         arr_data[a_idx]  <= c_dataIn;
         arr_tag[a_idx]   <= c_blockAddr[27:4];
         arr_valid[a_idx] <= 1'b1;
         arr_dirty[a_idx] <= 1'b0;
      end else if (c_wen && c_hit) begin
         for (int b = 0; b < 16; b++)
            if (c_bytesAccess[b]) arr_data[a_idx][8*b +: 8] <= c_dataIn[8*b +: 8];
         arr_dirty[a_idx] <= 1'b1;
      end
   end

   // Main memory: sparse block store, fixed latency mem_lat per request
   logic [127:0] backing [bit [27:0]];
   logic         mem_ready_auto, mem_ready_force, mem_auto;
   int           mem_lat, mem_cnt;

   assign mem_ready = mem_ready_auto | mem_ready_force;

   function automatic logic [31:0] init_word(input logic [29:0] wa);
      return (32'(wa) * 32'h9E3779B1) ^ 32'h12345678;
   endfunction

   function automatic logic [127:0] read_block(input logic [27:0] ba);
      logic [127:0] b;
      if (backing.exists(ba)) return backing[ba];
      for (int w = 0; w < 4; w++) b[32*w +: 32] = init_word({ba, 2'(w)});
      return b;
   endfunction

   always @(negedge clk) begin
      mem_rdata <= read_block(mem_addr);
      if (rst || !mem_req || !mem_auto) begin
         mem_cnt <= 0; mem_ready_auto <= 1'b0;
      end else if (mem_ready_auto) begin
         mem_cnt <= 1; mem_ready_auto <= (mem_lat == 1);
         if (mem_lat == 1 && mem_we) backing[mem_addr] = mem_wdata;
      end else begin
         mem_cnt <= mem_cnt + 1; mem_ready_auto <= (mem_cnt + 1 == mem_lat);
         if (mem_cnt + 1 == mem_lat && mem_we) backing[mem_addr] = mem_wdata;
      end
   end

   // Reference view of memory as seen by the CPU, and set residency
   logic [31:0] gold [bit [29:0]];
   logic        res_v [16];
   logic        res_d [16];
   logic [23:0] res_t [16];

   function automatic logic [31:0] gold_word(input logic [29:0] wa);
      logic [127:0] blk;
      if (gold.exists(wa)) return gold[wa];
      blk = read_block(wa[29:2]);
      return blk[32*wa[1:0] +: 32];
   endfunction

   int vec_cnt = 0, err_cnt = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   int           memwen_cnt;
   logic         wb_seen, fill_seen;
   logic [27:0]  wb_addr, fill_addr;
   logic [127:0] wb_data;

   task automatic do_op(input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output int stalls, output logic [31:0] rd);
      bit done;
      done = 0;
      @(negedge clk);
      cpu_ren = ren; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata; cpu_byte_en = be;
      stalls = 0; rd = '0; memwen_cnt = 0; wb_seen = 0; fill_seen = 0;
      for (int cyc = 0; cyc < 100 && !done; cyc++) begin
         #1;
         if (c_memWen) memwen_cnt++;
         if (mem_req && mem_we && !wb_seen) begin wb_seen = 1; wb_addr = mem_addr; wb_data = mem_wdata; end
         if (mem_req && !mem_we && !fill_seen) begin fill_seen = 1; fill_addr = mem_addr; end
         if (!cpu_stall) begin done = 1; rd = cpu_rdata; end
         else begin stalls++; @(negedge clk); end
      end
      if (!done) begin
         vec_cnt++; err_cnt++;
         $display("FAIL op_timeout: addr %h still stalled after 100 cycles", addr);
      end
   endtask

   task automatic preload(input logic [3:0] idx, input logic v, input logic [23:0] tag,
                          input logic d, input logic [127:0] data);
      @(negedge clk);
      cpu_ren = 0; cpu_wen = 0;
      pre_en = 1; pre_idx = idx; pre_valid = v; pre_tag = tag; pre_dirty = d; pre_data = data;
      @(negedge clk);
      pre_en = 0;
   endtask

   typedef struct {
      logic ren; logic wen; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;
      logic exp_stall; logic exp_cren; logic exp_cwen; logic [15:0] exp_ba;
      logic chk_rd; logic [31:0] exp_rd;
   } vec_t;
   vec_t tbl [4];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, %0d vectors applied", vec_cnt);
      $fatal(1, "watchdog");
   end

   initial begin
      int          st, ntg, nix, kind;
      logic [31:0] rd, addr, wd;
      logic [3:0]  be;
      logic [23:0] tg;
      logic [3:0]  ix;
      logic        resident, is_st;
      int          exp_st;
      logic [31:0] gw;

      tbl[0] = '{1'b1, 1'b0, 32'h48, 32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 32'hDEADBEEF};
      tbl[1] = '{1'b0, 1'b1, 32'h46, 32'hAABB0000, 4'hC, 1'b0, 1'b0, 1'b1, 16'h00C0, 1'b0, 32'h0};
      tbl[2] = '{1'b1, 1'b1, 32'h44, 32'h00001122, 4'h3, 1'b0, 1'b0, 1'b1, 16'h0030, 1'b0, 32'h0};
      tbl[3] = '{1'b0, 1'b0, 32'h0,  32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 32'h0};

      rst = 1; inv_all = 1; pre_en = 0; pre_idx = 0; pre_valid = 0; pre_dirty = 0;
      pre_tag = 0; pre_data = 0; mem_auto = 1; mem_lat = 3; mem_ready_force = 0;
      cpu_ren = 0; cpu_wen = 0; cpu_addr = 0; cpu_wdata = 0; cpu_byte_en = 0;
      repeat (2) @(negedge clk);
      rst = 0; inv_all = 0;
      #1;
      check("rst_stall", cpu_stall, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_memwen", c_memWen, 0);
      check("rst_c_ren", c_ren, 0);
      check("rst_c_wen", c_wen, 0);

      preload(4'd4, 1, 24'h0, 0, {32'h44443333, 32'hDEADBEEF, 32'h22221111, 32'h11110000});

      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         cpu_ren = tbl[i].ren; cpu_wen = tbl[i].wen; cpu_addr = tbl[i].addr;
         cpu_wdata = tbl[i].wdata; cpu_byte_en = tbl[i].be;
         #1;
         check($sformatf("vec%0d_stall", i), cpu_stall, tbl[i].exp_stall);
         check($sformatf("vec%0d_c_ren", i), c_ren, tbl[i].exp_cren);
         check($sformatf("vec%0d_c_wen", i), c_wen, tbl[i].exp_cwen);
         check($sformatf("vec%0d_bytes", i), c_bytesAccess, tbl[i].exp_ba);
         check($sformatf("vec%0d_baddr", i), c_blockAddr, tbl[i].addr[31:4]);
         check($sformatf("vec%0d_mem_req", i), mem_req, 0);
         if (tbl[i].chk_rd) check($sformatf("vec%0d_rdata", i), cpu_rdata, tbl[i].exp_rd);
         if (tbl[i].wen) check($sformatf("vec%0d_dataIn", i), c_dataIn, {4{tbl[i].wdata}});
      end

      // Clean miss, L=3
      mem_lat = 3;
      do_op(1, 0, 32'h100, 0, 0, st, rd);
      check("clean_stalls", st, 5);
      check("clean_fill_seen", fill_seen, 1);
      check("clean_fill_addr", fill_addr, 28'h10);
      check("clean_no_wb", wb_seen, 0);
      check("clean_memwen_pulses", memwen_cnt, 1);
      check("clean_rdata", rd, init_word(30'h40));

      // Dirty miss, L=3: victim tag 3 in set 0
      preload(4'd0, 1, 24'h3, 1, 128'h0123456789ABCDEF_FEDCBA9876543210);
      do_op(1, 0, 32'h104, 0, 0, st, rd);
      check("dirty_stalls", st, 8);
      check("dirty_wb_addr", wb_addr, 28'h30);
      check("dirty_wb_data", wb_data, 128'h0123456789ABCDEF_FEDCBA9876543210);
      check("dirty_fill_addr", fill_addr, 28'h10);
      check("dirty_memwen_pulses", memwen_cnt, 1);
      check("dirty_rdata", rd, init_word(30'h41));
      check("dirty_backing", read_block(28'h30), 128'h0123456789ABCDEF_FEDCBA9876543210);

`ifdef DCACHE_PERF_CNT_EN
      @(negedge clk); cpu_ren = 0; cpu_wen = 0; #1;
      check("perf_hits", perf_hits, 5);
      check("perf_misses", perf_misses, 2);
      check("perf_writebacks", perf_writebacks, 1);
`endif

      do_op(1, 0, 32'h44, 0, 0, st, rd);
      check("rb44_stalls", st, 0);
      check("rb44_rdata", rd, 32'hAABB1122);
      do_op(1, 0, 32'h40, 0, 0, st, rd);
      check("rb40_rdata", rd, 32'h11110000);

      // Reset in the second FILL cycle
      @(negedge clk); cpu_ren = 0; cpu_wen = 0; mem_auto = 0;
      @(negedge clk); cpu_ren = 1; cpu_addr = 32'h250; #1;
      check("rstfill_miss_stall", cpu_stall, 1);
      @(negedge clk); #1;
      check("rstfill_fill_req", mem_req, 1);
      check("rstfill_fill_we", mem_we, 0);
      @(negedge clk); rst = 1;
      @(negedge clk); rst = 0; #1;
      check("rstfill_mem_req", mem_req, 0);
      check("rstfill_lookup_stall", cpu_stall, 1);
      check("rstfill_idle_c_ren", c_ren, 1);
      cpu_ren = 0; #1;
      check("rstfill_no_req_stall", cpu_stall, 0);
      @(negedge clk); mem_ready_force = 1; #1;
      check("rstfill_late_ready_req", mem_req, 0);
      @(negedge clk); mem_ready_force = 0; #1;
      check("rstfill_late_ready_memwen", c_memWen, 0);
      check("rstfill_late_ready_req2", mem_req, 0);
      check("rstfill_late_ready_stall", cpu_stall, 0);
`ifdef DCACHE_PERF_CNT_EN
      check("rstfill_perf_cleared", {perf_hits, perf_misses, perf_writebacks}, 96'h0);
`endif
      mem_auto = 1;

      // Randomized traffic against the reference memory view
      @(negedge clk); inv_all = 1;
      @(negedge clk); inv_all = 0;
      gold.delete();
      for (int i = 0; i < 16; i++) begin res_v[i] = 0; res_d[i] = 0; res_t[i] = 0; end
      for (int n = 0; n < 200; n++) begin
         ntg = $urandom_range(0, 3); nix = $urandom_range(0, 3);
         tg = 24'(ntg); ix = 4'(nix);
         addr = {tg, ix, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         wd = $urandom; be = 4'($urandom_range(1, 15));
         kind = $urandom_range(0, 9);
         is_st = (kind >= 6);
         mem_lat = $urandom_range(1, 4);
         resident = res_v[ix] && (res_t[ix] == tg);
         exp_st = resident ? 0 : ((res_v[ix] && res_d[ix]) ? 2*mem_lat + 2 : mem_lat + 2);
         do_op(kind < 6 || kind == 9, is_st, addr, wd, be, st, rd);
         check($sformatf("rand%0d_stalls", n), st, exp_st);
         if (!is_st) begin
            check($sformatf("rand%0d_rdata", n), rd, gold_word(addr[31:2]));
         end else begin
            gw = gold_word(addr[31:2]);
            for (int b = 0; b < 4; b++) if (be[b]) gw[8*b +: 8] = wd[8*b +: 8];
            gold[addr[31:2]] = gw;
         end
         if (!resident) res_d[ix] = 0;
         res_v[ix] = 1; res_t[ix] = tg;
         if (is_st) res_d[ix] = 1;
      end

      @(negedge clk); cpu_ren = 0; cpu_wen = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
